// File: rtl/ace_loader_pkg.sv
// ace_loader_pkg: shared state encoding and defaults
// for the .ACE snapshot loader and its RLE expander.
package ace_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIT,
    S_CNT,
    S_VAL,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0]  ESC_BYTE_DEF  = 8'hED;
  localparam logic [15:0] BASE_ADDR_DEF = 16'h2000;

endpackage

// File: rtl/ace_snapshot_loader_expander.sv
// ace_rle_expander: decodes the LIT/CNT/VAL/RUN byte
// stream into one output byte per write, with ready.
// Ports: start/dl_on control, in_valid/in_data stream,
// out_valid/out_data/out_ready write side, load/last
// pulses (write-producing byte / final write), state.
module ace_rle_expander
  import ace_loader_pkg::*;
#(
  parameter logic [7:0] ESC_BYTE = ESC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dl_on,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       load,
  output logic       last,
  output state_e     state
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    load    = 1'b0;
    last    = 1'b0;
    if (start) begin
      state_d = S_LIT;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_LIT: begin
          if (!dl_on) begin
            state_d = S_IDLE;
          end else if (in_valid) begin
            if (in_data == ESC_BYTE) begin
              state_d = S_CNT;
            end else begin
              // a literal is a run of one
              data_d  = in_data;
              cnt_d   = 8'd1;
              valid_d = 1'b1;
              load    = 1'b1;
              state_d = S_RUN;
            end
          end
        end
        S_CNT: begin
          if (!dl_on) begin
            state_d = S_IDLE;
          end else if (in_valid) begin
            cnt_d = in_data;
            if (in_data == 8'd0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_VAL;
            end
          end
        end
        S_VAL: begin
          if (!dl_on) begin
            state_d = S_IDLE;
          end else if (in_valid) begin
            data_d  = in_data;
            valid_d = 1'b1;
            load    = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (valid_q && out_ready) begin
            // drop valid for a cycle between writes
            valid_d = 1'b0;
            cnt_d   = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              last    = 1'b1;
              state_d = dl_on ? S_LIT : S_IDLE;
            end
          end else if (!valid_q) begin
            valid_d = 1'b1;
          end
        end
        S_DONE: begin
          if (!dl_on) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign state     = state_q;

endmodule

// File: rtl/ace_snapshot_loader.sv
// ace_snapshot_loader: loads an RLE .ACE snapshot from
// the HPS ioctl stream into Jupiter Ace RAM.
// Ports: clk_sys/reset_n, ioctl_* (HPS stream, wait),
// ram_req/ram_ack/ram_addr/ram_data (arbiter write),
// cpu_reset/cpu_hold/busy/overflow status.
// Optional: ACE_LOADER_CHECKSUM_EN adds checksum[15:0].
module ace_snapshot_loader
  import ace_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter logic [15:0] LAST_ADDR    = 16'hFFFF,
  parameter logic [7:0]  FILE_INDEX   = 8'd1,
  parameter int unsigned RESET_CYCLES = 16,
  parameter logic [7:0]  ESC_BYTE     = ESC_BYTE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        ram_req,
  input  logic        ram_ack,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        cpu_reset,
  output logic        cpu_hold,
  output logic        busy,
  output logic        overflow
`ifdef ACE_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  logic        dl_q, dl_d;
  logic [15:0] addr_q, addr_d;
  logic        full_q, full_d;
  logic        ovf_q, ovf_d;
  logic        wait_q, wait_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;

  logic        start;
  logic        in_valid;
  logic        hs;
  logic        drop;
  logic        exp_ready;
  logic        exp_valid;
  logic [7:0]  exp_data;
  logic        exp_load;
  logic        exp_last;
  state_e      state;

  assign start = ioctl_download & ~dl_q
               & (ioctl_index == FILE_INDEX);
  // bytes arriving while stalled are dropped
  assign in_valid  = ioctl_wr & ~wait_q & ioctl_download;
  assign hs        = exp_valid & ~full_q & ram_ack;
  // past LAST_ADDR a write completes without a request
  assign drop      = exp_valid & full_q;
  assign exp_ready = hs | drop;

  ace_rle_expander #(
    .ESC_BYTE (ESC_BYTE)
  ) u_exp (
    .clk       (clk_sys),
    .reset_n   (reset_n),
    .start     (start),
    .dl_on     (ioctl_download),
    .in_valid  (in_valid),
    .in_data   (ioctl_dout),
    .out_ready (exp_ready),
    .out_valid (exp_valid),
    .out_data  (exp_data),
    .load      (exp_load),
    .last      (exp_last),
    .state     (state)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wait_q    <= 1'b0;
      rst_cnt_q <= '0;
    end else begin
      dl_q      <= dl_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      wait_q    <= wait_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  always_comb begin
    dl_d      = ioctl_download;
    addr_d    = addr_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    wait_d    = wait_q;
    rst_cnt_d = rst_cnt_q;
    if (rst_cnt_q != 16'd0) begin
      rst_cnt_d = rst_cnt_q - 16'd1;
    end
    if (start) begin
      // start wins over a same-cycle ack
      addr_d    = BASE_ADDR;
      full_d    = 1'b0;
      ovf_d     = 1'b0;
      wait_d    = 1'b0;
      rst_cnt_d = 16'(RESET_CYCLES);
    end else begin
      if (hs) begin
        if (addr_q == LAST_ADDR) begin
          full_d = 1'b1;
        end else begin
          addr_d = addr_q + 16'd1;
        end
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
      if (exp_load) begin
        wait_d = 1'b1;
      end else if (exp_last) begin
        wait_d = 1'b0;
      end
    end
  end

`ifdef ACE_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  always_comb begin
    sum_d = sum_q;
    if (start) begin
      sum_d = '0;
    end else if (hs) begin
      sum_d = sum_q + {8'd0, exp_data};
    end
  end

  assign checksum = sum_q;
`endif

  assign ioctl_wait = wait_q;
  assign ram_req    = exp_valid & ~full_q;
  assign ram_addr   = addr_q;
  assign ram_data   = exp_data;
  assign cpu_reset  = (rst_cnt_q != 16'd0);
  assign busy       = (state != S_IDLE);
  assign cpu_hold   = busy;
  assign overflow   = ovf_q;

endmodule
